multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the 4-bit-opcode datapath. Sequences every instruction through fetch, decode, execute, memory and writeback, and issues the 12-bit control word one instruction at a time. Adds memory request/acknowledge handshaking, branch resolution, illegal-opcode trapping, a memory-timeout halt and a retired-instruction counter. Sits between the instruction register/ALU flags and the register file, ALU, PC and memory interface.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before bus error
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  4  opcode field of instruction register
zero  in  1  ALU zero flag, valid in EXEC
mem_ack  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  memory write (qualifies mem_req)
ir_write  out  1  load instruction register
pc_write  out  1  PC <= PC+2
branch_taken  out  1  PC <= branch target
reg_write  out  1  register file write strobe, gated to WB
ctrl  out  12  {RegDst,BEQ,BNE,MemtoReg,MemWrite,ALUSrc,RegWrite,SLL,SRL,ALUctl[2:0]}
illegal  out  1  one-cycle pulse on undefined opcode
bus_error  out  1  sticky; memory timeout occurred
state  out  3  current FSM state (debug)
instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (async, rst_n=0): state=FETCH, ctrl=0, bus_error=0, instr_count=0, timeout counter=0, all strobes 0. Strobes are Moore outputs of the state register plus mem_ack/zero qualification below.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- FETCH: mem_req=1, mem_we=0. On mem_ack: ir_write=1, pc_write=1 same cycle; next DECODE. Otherwise stay.
- DECODE: ctrl register loads decode of op: add 0x822, sub 0x826, and 0x820, or 0x821, addi 0x062, lw 0x1E2, sw 0x0C2, slt 0x827, beq 0x406, bne 0x206, sll 0x830, srl 0x828. op 1100-1111: ctrl loads 0, illegal=1 for this cycle, next FETCH, not retired. Legal: next EXEC.
- EXEC: ALU evaluates. BEQ bit: branch_taken=zero. BNE bit: branch_taken=~zero. Branches retire here, next FETCH. MemWrite or MemtoReg set -> MEM. Otherwise -> WB.
- MEM: mem_req=1, mem_we=ctrl MemWrite. On mem_ack: sw retires, next FETCH; lw next WB.
- WB: reg_write=ctrl RegWrite (always 1 here); retire; next FETCH.
- Retire: instr_count+1 on exiting state; wraps 2^CNT_W-1 -> 0.
- Timeout: counter clears on entry to FETCH/MEM and on mem_ack; increments each cycle mem_req=1 without ack. Reaching MEM_TIMEOUT -> bus_error=1, state HALT. HALT: all strobes 0, stays until reset; ctrl and instr_count hold.
- mem_ack outside FETCH/MEM ignored. ir_write/pc_write never assert outside FETCH.
- Latency with immediate ack: branch 3 cycles, ALU/sw 4, lw 5.
- Reset mid-instruction: immediate abandon; no write strobe may assert while rst_n=0.

Decomposition:
- Shared package: state encodings, opcode constants, 12-bit control-word constants, ctrl bit indices.
- One sub-module natural: op_decode (combinational op -> 12-bit ctrl + illegal flag), instantiated in DECODE path.

Test Plan:
- Reset release, mem_ack tied 1, op=0000 (add) -> states 0,1,2,4; ctrl=0x822 from cycle 3; reg_write=1 only in WB; instr_count=1 after 4 cycles.
- op=0101 (lw), mem_ack low 3 cycles in MEM -> mem_req high 4 MEM cycles, mem_we=0, then WB reg_write=1; 8 cycles total.
- op=1000 (beq) zero=1 -> branch_taken=1 in EXEC; zero=0 -> 0; op=1001 (bne) inverse; each retires in 3 cycles, no reg_write.
- op=1110 -> illegal pulses one cycle in DECODE, ctrl=0, back to FETCH, instr_count unchanged.
- mem_ack held 0 in FETCH -> bus_error=1 after 16 cycles, state=7, strobes 0 until rst_n asserted.
- rst_n pulsed low mid-MEM of sw -> mem_req drops immediately, state=0, instr_count=0, no mem_we after release until next MEM.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM state encoding,
// opcode values, decoded control words and control-word bit positions.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_SLL  = 4'hA;
    localparam logic [3:0] OP_SRL  = 4'hB;

    localparam logic [11:0] CTRL_ADD  = 12'h822;
    localparam logic [11:0] CTRL_SUB  = 12'h826;
    localparam logic [11:0] CTRL_AND  = 12'h820;
    localparam logic [11:0] CTRL_OR   = 12'h821;
    localparam logic [11:0] CTRL_ADDI = 12'h062;
    localparam logic [11:0] CTRL_LW   = 12'h1E2;
    localparam logic [11:0] CTRL_SW   = 12'h0C2;
    localparam logic [11:0] CTRL_SLT  = 12'h827;
    localparam logic [11:0] CTRL_BEQ  = 12'h406;
    localparam logic [11:0] CTRL_BNE  = 12'h206;
    localparam logic [11:0] CTRL_SLL  = 12'h830;
    localparam logic [11:0] CTRL_SRL  = 12'h828;

    localparam int CB_REGDST   = 11;
    localparam int CB_BEQ      = 10;
    localparam int CB_BNE      = 9;
    localparam int CB_MEMTOREG = 8;
    localparam int CB_MEMWRITE = 7;
    localparam int CB_ALUSRC   = 6;
    localparam int CB_REGWRITE = 5;
    localparam int CB_SLL      = 4;
    localparam int CB_SRL      = 3;

endpackage

// File: rtl/multicycle_sequencer_op_decode.sv
// Combinational opcode decoder: maps the 4-bit opcode to its 12-bit control
// word and flags the undefined opcodes 1100-1111.
module multicycle_sequencer_op_decode
    import multicycle_sequencer_pkg::*;
(
    input  logic [3:0]  op,
    output logic [11:0] ctrl,
    output logic        illegal
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  ctrl = CTRL_ADD;
            OP_SUB:  ctrl = CTRL_SUB;
            OP_AND:  ctrl = CTRL_AND;
            OP_OR:   ctrl = CTRL_OR;
            OP_ADDI: ctrl = CTRL_ADDI;
            OP_LW:   ctrl = CTRL_LW;
            OP_SW:   ctrl = CTRL_SW;
            OP_SLT:  ctrl = CTRL_SLT;
            OP_BEQ:  ctrl = CTRL_BEQ;
            OP_BNE:  ctrl = CTRL_BNE;
            OP_SLL:  ctrl = CTRL_SLL;
            OP_SRL:  ctrl = CTRL_SRL;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback sequencing with
// memory handshake, branch resolution, illegal-op trap and timeout halt.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       op,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch_taken,
    output logic             reg_write,
    output logic [11:0]      ctrl,
    output logic             illegal,
    output logic             bus_error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [11:0]       ctrl_q, ctrl_d;
    logic              bus_error_q, bus_error_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [11:0]       dec_ctrl;
    logic              dec_illegal;
    logic              retire;
    logic              req_s, we_s, irw_s, pcw_s, br_s, rw_s, ill_s;

    multicycle_sequencer_op_decode u_op_decode (
        .op      (op),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        bus_error_d = bus_error_q;
        retire      = 1'b0;
        req_s       = 1'b0;
        we_s        = 1'b0;
        irw_s       = 1'b0;
        pcw_s       = 1'b0;
        br_s        = 1'b0;
        rw_s        = 1'b0;
        ill_s       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                req_s = 1'b1;
                if (mem_ack) begin
                    irw_s   = 1'b1;
                    pcw_s   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctrl_d = dec_ctrl;
                if (dec_illegal) begin
                    ill_s   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                br_s = (ctrl_q[CB_BEQ] & zero) | (ctrl_q[CB_BNE] & ~zero);
                if (ctrl_q[CB_BEQ] | ctrl_q[CB_BNE]) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (ctrl_q[CB_MEMWRITE] | ctrl_q[CB_MEMTOREG]) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                // The lw word also carries MemWrite; MemtoReg marks it as a read.
                req_s = 1'b1;
                we_s  = ctrl_q[CB_MEMWRITE] & ~ctrl_q[CB_MEMTOREG];
                if (mem_ack) begin
                    if (ctrl_q[CB_MEMTOREG]) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                rw_s    = ctrl_q[CB_REGWRITE];
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
            end
            default: state_d = ST_FETCH;
        endcase

        // Counter is zero whenever no request is outstanding, so entry clears it.
        tmo_d = (req_s && !mem_ack) ? tmo_q + 1'b1 : '0;
        if (req_s && !mem_ack && tmo_q == TMO_LAST) begin
            bus_error_d = 1'b1;
            state_d     = ST_HALT;
        end

        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            ctrl_q      <= '0;
            bus_error_q <= 1'b0;
            cnt_q       <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            bus_error_q <= bus_error_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    // Strobes are forced low while reset is held, even though FETCH requests.
    assign mem_req      = rst_n & req_s;
    assign mem_we       = rst_n & we_s;
    assign ir_write     = rst_n & irw_s;
    assign pc_write     = rst_n & pcw_s;
    assign branch_taken = rst_n & br_s;
    assign reg_write    = rst_n & rw_s;
    assign illegal      = rst_n & ill_s;

    assign ctrl        = ctrl_q;
    assign bus_error   = bus_error_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule
